controller_sysid_checker: RTL and testbench

//   Avalon-MM read master that interrogates the system-ID slave at boot or on request.

---
 rtl/controller_sysid_checker_if.sv | 22 ++
 rtl/controller_sysid_checker.sv | 135 +++++++++++++
 tb/tb_controller_sysid_checker.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_sysid_checker_if.sv
// Avalon-MM read bus between the sysid checker (master) and the
// system-ID control_slave port (slave).
interface controller_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/controller_sysid_checker.sv
// System-ID checker: reads the ID word (address 0) and the timestamp word
// (address 1) from the sysid slave, compares both against build-time values
// and reports pass/fail/timeout to the controller supervisor.
module controller_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd49153,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1540180295,
  parameter int unsigned TIMEOUT_CYCLES     = 256,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  controller_sysid_checker_if.master        bus,
  output logic                              busy,
  output logic                              done,
  output logic                              id_ok,
  output logic                              ts_ok,
  output logic                              timeout,
  output logic [31:0]                       id_value,
  output logic [31:0]                       ts_value
);

  // A zero timeout disables the counter, but it still needs a legal width.
  localparam int          CW         = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LAST_INT   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] LAST_STALL = LAST_INT[CW-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            auto_pending;
  logic            rd_active;
  logic            accept;
  logic            stall_limit;
  logic            timeout_fire;
  logic [CW-1:0]   stall_cnt;
  logic            address_q;

  // The stall that would take the count to TIMEOUT_CYCLES is the last one allowed.
  assign stall_limit  = (TIMEOUT_CYCLES != 0) && (stall_cnt == LAST_STALL);
  assign accept       = rd_active && !bus.avm_waitrequest;
  assign timeout_fire = rd_active && bus.avm_waitrequest && stall_limit;

  assign bus.avm_read    = rd_active;
  assign bus.avm_address = address_q;
  assign busy            = rd_active;
  assign done            = (state_q == DONE);

  // Next-state decode: start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_d   = state_q;
    rd_active = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || auto_pending) state_d = RD_ID;
      end
      RD_ID: begin
        rd_active = 1'b1;
        if (!bus.avm_waitrequest) state_d = RD_TS;
        else if (stall_limit)     state_d = DONE;
      end
      RD_TS: begin
        rd_active = 1'b1;
        if (!bus.avm_waitrequest) state_d = DONE;
        else if (stall_limit)     state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; the auto-start request lives for exactly the first post-reset cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      auto_pending <= AUTO_START;
    end else begin
      state_q      <= state_d;
      auto_pending <= 1'b0;
    end
  end

  // Per-read stall counter, restarted on every accept and every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (accept || (state_d != state_q)) begin
      stall_cnt <= '0;
    end else if (rd_active && bus.avm_waitrequest) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Captured words, result flags and the held bus address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_value  <= '0;
      ts_value  <= '0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
      address_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && (state_d == RD_ID)) begin
        id_ok     <= 1'b0;
        ts_ok     <= 1'b0;
        timeout   <= 1'b0;
        address_q <= 1'b0;
      end
      if ((state_q == RD_ID) && accept) begin
        id_value  <= bus.avm_readdata;
        address_q <= 1'b1;
      end
      if ((state_q == RD_TS) && accept) begin
        ts_value <= bus.avm_readdata;
        id_ok    <= (id_value == EXPECTED_ID);
        ts_ok    <= (bus.avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (timeout_fire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_controller_sysid_checker.sv
// Bench for controller_sysid_checker: each check is planned as a transaction
// (start cycle, stall lengths, returned words) and expanded into a per-cycle
// table of expected outputs and slave stimulus.
module tb_controller_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd49153;
  localparam logic [31:0] EXP_TS = 32'd1540180295;
  localparam int          TO     = 4;
  localparam int          MAXC   = 2048;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  controller_sysid_checker_if bus();

  controller_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TO),
    .AUTO_START         (1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  bit          e_read  [MAXC];
  bit          e_addr  [MAXC];
  bit          e_busy  [MAXC];
  bit          e_done  [MAXC];
  bit          e_idok  [MAXC];
  bit          e_tsok  [MAXC];
  bit          e_to    [MAXC];
  logic [31:0] e_idv   [MAXC];
  logic [31:0] e_tsv   [MAXC];
  bit          s_start [MAXC];
  bit          s_wait  [MAXC];
  logic [31:0] s_data  [MAXC];

  int cyc     = 0;
  int seg_id  = 0;
  bit cmp_en  = 1'b0;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s seg %0d cycle %0d: got %h, expected %h", name, seg_id, cyc, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_read"},    32'(bus.avm_read),    32'd0);
    check({tag, "_addr"},    32'(bus.avm_address), 32'd0);
    check({tag, "_busy"},    32'(busy),            32'd0);
    check({tag, "_done"},    32'(done),            32'd0);
    check({tag, "_id_ok"},   32'(id_ok),           32'd0);
    check({tag, "_ts_ok"},   32'(ts_ok),           32'd0);
    check({tag, "_timeout"}, 32'(timeout),         32'd0);
    check({tag, "_id_val"},  id_value,             32'd0);
    check({tag, "_ts_val"},  ts_value,             32'd0);
  endtask

  task automatic clear_plan();
    for (int k = 0; k < MAXC; k++) begin
      e_read[k] = 0; e_addr[k] = 0; e_busy[k] = 0; e_done[k] = 0;
      e_idok[k] = 0; e_tsok[k] = 0; e_to[k] = 0;
      e_idv[k] = '0; e_tsv[k] = '0;
      s_start[k] = 0;
      s_wait[k]  = 1'($urandom % 2);
      s_data[k]  = $urandom;
    end
  endtask

  // One read: w stall cycles then an accept, or TO stalls and an abort.
  task automatic plan_read(input int first, input int w, input bit addr,
                           output int last, output bit timed_out);
    int len;
    timed_out = (w >= TO);
    len       = timed_out ? TO : w + 1;
    for (int k = first; k < first + len; k++) begin
      e_read[k] = 1;
      e_busy[k] = 1;
      e_addr[k] = addr;
      s_wait[k] = timed_out ? 1'b1 : (k < first + w);
    end
    last = first + len - 1;
  endtask

  // A check triggered in IDLE at cycle c; returns the cycle of its done pulse.
  task automatic add_check(input int c, input int w0, input int w1,
                           input logic [31:0] d0, input logic [31:0] d1, output int dc);
    int a0, a1;
    bit to0, to1, to;
    to1 = 0;
    a1  = 0;
    for (int k = c + 1; k < MAXC; k++) begin
      e_idok[k] = 0; e_tsok[k] = 0; e_to[k] = 0;
    end
    plan_read(c + 1, w0, 1'b0, a0, to0);
    if (!to0) begin
      s_data[a0] = d0;
      for (int k = a0 + 1; k < MAXC; k++) e_idv[k] = d0;
      plan_read(a0 + 1, w1, 1'b1, a1, to1);
      if (!to1) begin
        s_data[a1] = d1;
        for (int k = a1 + 1; k < MAXC; k++) e_tsv[k] = d1;
      end
    end
    to = to0 || to1;
    dc = (to0 ? a0 : a1) + 1;
    e_done[dc] = 1;
    for (int k = dc; k < MAXC; k++) begin
      e_idok[k] = !to && (d0 == EXP_ID);
      e_tsok[k] = !to && (d1 == EXP_TS);
      e_to[k]   = to;
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom % 10);
    if (r < 3) return 0;
    else if (r < 8) return 1 + int'($urandom % 3);
    else return TO + int'($urandom % 3);
  endfunction

  function automatic logic [31:0] pick_data(input logic [31:0] good);
    logic [31:0] one;
    case ($urandom % 4)
      0, 1:    return good;
      2: begin
        one = 32'd1 << ($urandom % 32);
        return good ^ one;
      end
      default: return $urandom;
    endcase
  endfunction

  task automatic build_directed(output int last);
    int dc;
    clear_plan();
    s_start[0]  = 1; add_check(0,  0, 0, EXP_ID,        EXP_TS, dc);
    s_start[5]  = 1; add_check(5,  0, 0, 32'h0000C002,  EXP_TS, dc);
    s_start[6]  = 1;
    s_start[8]  = 1;
    s_start[10] = 1; add_check(10, 3, 3, EXP_ID,        EXP_TS, dc);
    s_start[21] = 1; add_check(21, 9, 0, EXP_ID,        EXP_TS, dc);
    s_start[28] = 1; add_check(28, 1, 5, 32'h12345678,  EXP_TS, dc);
    s_start[37] = 1; add_check(37, 0, 2, EXP_ID,        EXP_TS, dc);
    last = 40;
  endtask

  task automatic build_random(output int last);
    int c, dc;
    clear_plan();
    c = 0;
    dc = 0;
    s_start[0] = 1'($urandom % 2);
    for (int n = 0; n < 50; n++) begin
      if (n > 0) s_start[c] = 1;
      add_check(c, pick_wait(), pick_wait(), pick_data(EXP_ID), pick_data(EXP_TS), dc);
      for (int k = c + 1; k <= dc; k++) s_start[k] = ($urandom % 3 == 0);
      c = dc + 1 + int'($urandom % 4);
    end
    last = dc + 3;
  endtask

  task automatic apply_stimulus(input int k);
    start               = s_start[k];
    bus.avm_waitrequest = s_wait[k];
    bus.avm_readdata    = s_data[k];
  endtask

  task automatic run_segment(input int last);
    @(posedge clock);
    #1;
    cyc = 0;
    apply_stimulus(0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    while (cyc < last) begin
      @(posedge clock);
      #1;
      cyc++;
      apply_stimulus(cyc);
    end
    @(negedge clock);
    #1;
  endtask

  // Compare every output against the planned table once per cycle, mid-cycle.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("read",    32'(bus.avm_read), 32'(e_read[cyc]));
      if (e_read[cyc]) check("addr", 32'(bus.avm_address), 32'(e_addr[cyc]));
      check("busy",    32'(busy),         32'(e_busy[cyc]));
      check("done",    32'(done),         32'(e_done[cyc]));
      check("id_ok",   32'(id_ok),        32'(e_idok[cyc]));
      check("ts_ok",   32'(ts_ok),        32'(e_tsok[cyc]));
      check("timeout", 32'(timeout),      32'(e_to[cyc]));
      check("id_val",  id_value,          e_idv[cyc]);
      check("ts_val",  ts_value,          e_tsv[cyc]);
      if (seg_id == 0) begin
        case (cyc)
          1: begin
            check("lit_c1_read", 32'(bus.avm_read), 32'd1);
            check("lit_c1_addr", 32'(bus.avm_address), 32'd0);
          end
          2: begin
            check("lit_c2_read", 32'(bus.avm_read), 32'd1);
            check("lit_c2_addr", 32'(bus.avm_address), 32'd1);
          end
          3: begin
            check("lit_c3_done",  32'(done),  32'd1);
            check("lit_c3_id_ok", 32'(id_ok), 32'd1);
            check("lit_c3_ts_ok", 32'(ts_ok), 32'd1);
            check("lit_c3_to",    32'(timeout), 32'd0);
          end
          8: begin
            check("lit_c8_done",  32'(done),  32'd1);
            check("lit_c8_id_ok", 32'(id_ok), 32'd0);
            check("lit_c8_ts_ok", 32'(ts_ok), 32'd1);
            check("lit_c8_idval", id_value,   32'h0000C002);
          end
          9:  check("lit_c9_busy",   32'(busy), 32'd0);
          19: check("lit_c19_done",  32'(done), 32'd1);
          25: check("lit_c25_read",  32'(bus.avm_read), 32'd1);
          26: begin
            check("lit_c26_done", 32'(done),         32'd1);
            check("lit_c26_to",   32'(timeout),      32'd1);
            check("lit_c26_read", 32'(bus.avm_read), 32'd0);
          end
          40: check("lit_c40_addr", 32'(bus.avm_address), 32'd1);
          default: ;
        endcase
      end
    end
  end

  // Directed segment, reset in the middle of a timestamp read, then a random segment.
  initial begin
    int last;
    reset               = 1'b1;
    start               = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("por");

    seg_id = 0;
    build_directed(last);
    run_segment(last);
    cmp_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_reset_state("rst_in_rd_ts");

    seg_id = 1;
    build_random(last);
    run_segment(last);
    cmp_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_reset_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
